// File: rtl/hack_exec_ctrl_if.sv
// hack_exec_ctrl_if
// Bundles every non-clock, non-reset signal of the Hack execute controller:
//   instruction handshake : instr, instr_valid, instr_ready
//   memory bus            : in_m, mem_ack, out_m, write_m, address_m
//   ALU connection        : alu_x, alu_y, alu_ctl, alu_out, alu_zr, alu_ng
//   status                : pc, halted
// modport master : the execute controller
// modport slave  : everything around it (fetch unit, memory, ALU)
interface hack_exec_ctrl_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] in_m;
    logic        mem_ack;
    logic [15:0] out_m;
    logic        write_m;
    logic [14:0] address_m;
    logic [14:0] pc;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_ctl;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic        halted;

    modport master (
        input  instr, instr_valid, in_m, mem_ack, alu_out, alu_zr, alu_ng,
        output instr_ready, out_m, write_m, address_m, pc,
               alu_x, alu_y, alu_ctl, halted
    );

    modport slave (
        output instr, instr_valid, in_m, mem_ack, alu_out, alu_zr, alu_ng,
        input  instr_ready, out_m, write_m, address_m, pc,
               alu_x, alu_y, alu_ctl, halted
    );
endinterface

// File: rtl/hack_exec_ctrl.sv
// hack_exec_ctrl
// Multi-cycle execute controller for the 16-bit Hack CPU. Holds A, D, PC and
// the instruction register, drives an external ALU and commits its result.
// Sequence: FETCH (accept instr) -> EXEC (ALU evaluates, commit at edge)
//           -> optional WRITE (hold memory write until mem_ack) -> FETCH.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : hack_exec_ctrl_if.master (handshake, memory bus, ALU, pc, halted)
// Optional feature macro: HACK_HALT_DETECT_EN
//   When defined, a "@here; 0;JMP" style self-loop (A-instruction pointing at
//   itself followed by an unconditional jump) parks the controller in HALT
//   until reset. When undefined, halted is tied low and HALT does not exist.
module hack_exec_ctrl (
    input  logic             clk,
    input  logic             reset,
    hack_exec_ctrl_if.master bus
);

`ifdef HACK_HALT_DETECT_EN
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WRITE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;
`endif

    state_t      state_r, state_nx;
    logic [15:0] a_r, a_nx;
    logic [15:0] d_r, d_nx;
    logic [14:0] pc_r, pc_nx;
    logic [15:0] ir_r, ir_nx;
    logic [15:0] out_m_r, out_m_nx;
    logic        write_m_r, write_m_nx;
    logic        prev_a_r, prev_a_nx;
    // A as it was before the EXEC commit; the write target even when d1 reloads A
    logic [14:0] wr_addr_r, wr_addr_nx;
    logic        jump_taken;
`ifdef HACK_HALT_DETECT_EN
    // Halt detected on an M-writing instruction; taken once WRITE finishes
    logic        halt_pend_r, halt_pend_nx;
    logic        halt_hit;
`endif

    // Jump decision from the ALU flags of the instruction in IR
    assign jump_taken = (ir_r[2] & bus.alu_ng) |
                        (ir_r[1] & bus.alu_zr) |
                        (ir_r[0] & ~bus.alu_ng & ~bus.alu_zr);

`ifdef HACK_HALT_DETECT_EN
    // Self-loop: previous instruction loaded A with the address of itself
    assign halt_hit = ir_r[15] & (ir_r[2:0] == 3'b111) & prev_a_r &
                      (a_r[14:0] == (pc_r - 15'd1));
    assign bus.halted = (state_r == ST_HALT);
`else
    assign bus.halted = 1'b0;
`endif

    assign bus.instr_ready = (state_r == ST_FETCH);
    assign bus.pc          = pc_r;
    assign bus.out_m       = out_m_r;
    assign bus.write_m     = write_m_r;
    assign bus.address_m   = (state_r == ST_WRITE) ? wr_addr_r : a_r[14:0];
    assign bus.alu_x       = d_r;
    assign bus.alu_y       = ir_r[12] ? bus.in_m : a_r;
    assign bus.alu_ctl     = ir_r[11:6];

    // State register and architectural registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_FETCH;
            a_r         <= 16'h0000;
            d_r         <= 16'h0000;
            pc_r        <= 15'h0000;
            ir_r        <= 16'h0000;
            out_m_r     <= 16'h0000;
            write_m_r   <= 1'b0;
            prev_a_r    <= 1'b0;
            wr_addr_r   <= 15'h0000;
`ifdef HACK_HALT_DETECT_EN
            halt_pend_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_nx;
            a_r         <= a_nx;
            d_r         <= d_nx;
            pc_r        <= pc_nx;
            ir_r        <= ir_nx;
            out_m_r     <= out_m_nx;
            write_m_r   <= write_m_nx;
            prev_a_r    <= prev_a_nx;
            wr_addr_r   <= wr_addr_nx;
`ifdef HACK_HALT_DETECT_EN
            halt_pend_r <= halt_pend_nx;
`endif
        end
    end

    // Next-state and commit logic
    always_comb begin
        state_nx     = state_r;
        a_nx         = a_r;
        d_nx         = d_r;
        pc_nx        = pc_r;
        ir_nx        = ir_r;
        out_m_nx     = out_m_r;
        write_m_nx   = write_m_r;
        prev_a_nx    = prev_a_r;
        wr_addr_nx   = wr_addr_r;
`ifdef HACK_HALT_DETECT_EN
        halt_pend_nx = halt_pend_r;
`endif
        case (state_r)
            ST_FETCH: begin
                if (bus.instr_valid) begin
                    ir_nx    = bus.instr;
                    state_nx = ST_EXEC;
                end else begin
                    state_nx = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (!ir_r[15]) begin
                    a_nx      = {1'b0, ir_r[14:0]};
                    pc_nx     = pc_r + 15'd1;
                    prev_a_nx = 1'b1;
                    state_nx  = ST_FETCH;
                end else begin
                    if (ir_r[5]) begin
                        a_nx = bus.alu_out;
                    end else begin
                        a_nx = a_r;
                    end
                    if (ir_r[4]) begin
                        d_nx = bus.alu_out;
                    end else begin
                        d_nx = d_r;
                    end
                    // Target is the pre-commit A, never the freshly loaded one
                    pc_nx     = jump_taken ? a_r[14:0] : (pc_r + 15'd1);
                    prev_a_nx = 1'b0;
                    if (ir_r[3]) begin
                        out_m_nx     = bus.alu_out;
                        write_m_nx   = 1'b1;
                        wr_addr_nx   = a_r[14:0];
`ifdef HACK_HALT_DETECT_EN
                        halt_pend_nx = halt_hit;
`endif
                        state_nx     = ST_WRITE;
                    end else begin
`ifdef HACK_HALT_DETECT_EN
                        state_nx = halt_hit ? ST_HALT : ST_FETCH;
`else
                        state_nx = ST_FETCH;
`endif
                    end
                end
            end
            ST_WRITE: begin
                if (bus.mem_ack) begin
                    write_m_nx   = 1'b0;
`ifdef HACK_HALT_DETECT_EN
                    halt_pend_nx = 1'b0;
                    state_nx     = halt_pend_r ? ST_HALT : ST_FETCH;
`else
                    state_nx     = ST_FETCH;
`endif
                end else begin
                    state_nx = ST_WRITE;
                end
            end
`ifdef HACK_HALT_DETECT_EN
            ST_HALT: begin
                state_nx = ST_HALT;
            end
`endif
            default: begin
                state_nx = ST_FETCH;
            end
        endcase
    end

endmodule

// File: doc/hack_exec_ctrl.md
# hack_exec_ctrl

Multi-cycle execute controller for the 16-bit Hack CPU. It accepts instructions over a valid/ready handshake and holds the A, D and PC registers. It drives the operands and the six control bits of the 16-bit ALU, then consumes the ALU result and its zr/ng flags to commit register writes, memory writes and jumps. It sits directly upstream of the ALU, which is instantiated alongside it at CPU level.

## Interface
- No parameters. Widths are fixed: 16-bit data, 15-bit address/PC.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `instr` in 16: instruction word.
- `instr_valid` in 1: `instr` is valid.
- `instr_ready` out 1: controller accepts `instr` this cycle.
- `in_m` in 16: memory read data (M) at `address_m`.
- `mem_ack` in 1: memory has completed a write.
- `out_m` out 16: memory write data.
- `write_m` out 1: memory write request.
- `address_m` out 15: memory address, equal to A[14:0].
- `pc` out 15: address of the next instruction to fetch.
- `alu_x` out 16: ALU x operand, equal to D.
- `alu_y` out 16: ALU y operand, equal to `IR[12] ? in_m : A`.
- `alu_ctl` out 6: {zx,nx,zy,ny,f,no}, equal to IR[11:6].
- `alu_out` in 16: ALU result.
- `alu_zr` in 1: ALU zero flag.
- `alu_ng` in 1: ALU negative flag.
- `halted` out 1: self-loop detected (see Configuration).

## Operation
- Registers: A[15:0], D[15:0], PC[14:0], IR[15:0], out_m latch, write_m flop, prev_a flag, state.
- States and transitions:
  - FETCH: `instr_ready`=1. On `instr_valid`: IR<=instr, go to EXEC. With `instr_valid`=0, stay and hold all registers.
  - EXEC: `instr_ready`=0. The ALU is driven from IR/A/D; commit happens at the end of the cycle.
    - A-instruction (IR[15]=0): A<={1'b0,IR[14:0]}, PC<=PC+1, prev_a<=1, go to FETCH.
    - C-instruction (IR[15]=1, IR[14:13] ignored): dest d1=IR[5] loads A<=alu_out, d2=IR[4] loads D<=alu_out, d3=IR[3] writes M.
    - Jump: j1=IR[2] taken if ng; j2=IR[1] taken if zr; j3=IR[0] taken if !ng&!zr. Taken: PC<=A_old[14:0]; else PC<=PC+1.
    - If d3: out_m<=alu_out, write_m<=1, go to WRITE. Else go to FETCH. prev_a<=0.
  - WRITE: `instr_ready`=0. Hold `write_m`, `out_m` and `address_m` until `mem_ack`=1 is sampled. Then write_m<=0, go to FETCH.
  - HALT: `instr_ready`=0 and `halted`=1. Left only by reset.
- All EXEC operands use pre-commit values. The jump target and the write address are A_old, even when d1=1.
  - Consequence: `address_m` is sourced from a captured A_old during WRITE, not from the updated A.
- PC arithmetic is 15-bit modulo: 0x7FFF+1 = 0x0000.
- `mem_ack` is ignored outside WRITE.

## Timing
- Reset values: A=0, D=0, PC=0, IR=0, out_m=0, write_m=0, address_m=0, halted=0, prev_a=0, state FETCH. `instr_ready`=1 after reset.
- Latency per instruction:
  - Non-memory-writing instruction: 2 cycles (FETCH accept, EXEC).
  - M-write: 3 cycles plus the ack wait.
- `write_m` rises on the cycle after EXEC and falls on the cycle after `mem_ack`.
- An ack in the first WRITE cycle gives a one-cycle write pulse.
- Reset asserted in any state, including mid-WRITE, clears all state asynchronously. `write_m` drops immediately and no ack is awaited.
- `pc`, A and D change only at the EXEC clock edge.

## Configuration
- `HACK_HALT_DETECT_EN`
  - Defined:
    - In EXEC, a C-instruction with jjj=111, prev_a=1 and A_old[14:0]==PC-1 enters HALT instead of FETCH. PC is still loaded with the target.
    - Register/memory commits of that instruction still occur; an M-write completes WRITE first and then enters HALT.
  - Undefined:
    - `halted` is tied 0 and the HALT state does not exist.
    - The loop executes indefinitely through the normal handshake.

## Test plan
- Reset, then feed 0x0005 and 0xEC10 (D=A):
  - A=5, D=5, pc=2.
  - `alu_ctl`=6'b110000 during the second EXEC.
- A=100 (0x0064), D=5, then 0xE7E8 (AM=D+1), with `mem_ack` delayed 3 cycles:
  - `write_m`=1, `address_m`=100, `out_m`=6 held stable until the ack.
  - A=6 after EXEC. pc advances by 2.
- D=0, A=20, then 0xE302 (D;JEQ): pc=20.
  - Repeat with D=1: pc=old+1. No memory write.
- At pc=7 feed 0x0007, then 0xEA87 (0;JMP):
  - With `HACK_HALT_DETECT_EN`: `halted`=1 and `instr_ready`=0 permanently, pc=7.
  - Without it: pc=7, `instr_ready`=1, `halted`=0.
- Feed 0x7FFF then 0xEA87: pc=0x7FFF. Then feed 0xEC10: pc wraps to 0.
- Assert reset during WRITE: `write_m`=0 the same cycle, A=D=pc=0, `instr_ready`=1 after release.
